// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID queue, including the
// branch-redirect return path to fetch.
interface if_id_queue_if;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        fetch_hold;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;
    logic        flush_req;
    logic [31:0] flush_offset;
    logic        Br_taken;
    logic [31:0] Br_offset;

    modport master (
        output in_valid, in_pc, in_inst, out_ready, flush_req, flush_offset,
        input  fetch_hold, out_valid, out_pc, out_inst, Br_taken, Br_offset
    );

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready, flush_req, flush_offset,
        output fetch_hold, out_valid, out_pc, out_inst, Br_taken, Br_offset
    );
endinterface

// File: rtl/if_id_queue.sv
// First-word-fall-through queue between fetch and decode; a flush empties it
// and issues a one-cycle redirect pulse back to fetch.
module if_id_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input logic          clk,
    input logic          rst,
    if_id_queue_if.slave bus
);

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   count;
    logic [31:0]   br_offset_q;
    logic [63:0]   head;
    logic          br_taken;
    logic          full;
    logic          suppress;
    logic          valid;
    logic          push;
    logic          pop;

    // The pair presented during the flush and redirect cycles is wrong-path.
    assign br_taken = (state == REDIRECT);
    assign suppress = bus.flush_req | br_taken;
    assign full     = (count == (AW+1)'(DEPTH));
    assign valid    = (count != '0) & ~suppress;
    assign push     = bus.in_valid & ~full & ~suppress;
    assign pop      = valid & bus.out_ready;
    assign head     = mem[rp];

    assign bus.fetch_hold = full;
    assign bus.out_valid  = valid;
    assign bus.out_pc     = valid ? head[63:32] : 32'h0;
    assign bus.out_inst   = valid ? head[31:0]  : 32'h0;
    assign bus.Br_taken   = br_taken;
    assign bus.Br_offset  = br_offset_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (bus.flush_req)  state_nxt = REDIRECT;
            REDIRECT: if (!bus.flush_req) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (bus.flush_req) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop)  rp <= rp + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               br_offset_q <= '0;
        else if (bus.flush_req) br_offset_q <= bus.flush_offset;
    end

    // NOTE: storage is left unreset; out_valid gating hides stale contents.
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= {bus.in_pc, bus.in_inst};
    end

endmodule
